// File: rtl/jtag_scan_ctrl_if.sv
// Signal bundle between the TAP controller and the scan data path.
// master drives the TAP state indicators and parallel USER capture data; slave returns the scan results.
interface jtag_scan_ctrl_if #(
  parameter int USER_W = 8
);
  logic              TDI;
  logic              Test_Logic_Reset_in;
  logic              Capture_IR_in;
  logic              Shift_IR_in;
  logic              Update_IR_in;
  logic              Capture_DR_in;
  logic              Shift_DR_in;
  logic              Update_DR_in;
  logic [USER_W-1:0] user_dr_in;
  logic              TDO;
  logic              tdo_en;
  logic [3:0]        ir_out;
  logic [USER_W-1:0] user_dr_out;
  logic              user_dr_valid;

  modport master (
    output TDI, Test_Logic_Reset_in, Capture_IR_in, Shift_IR_in, Update_IR_in,
           Capture_DR_in, Shift_DR_in, Update_DR_in, user_dr_in,
    input  TDO, tdo_en, ir_out, user_dr_out, user_dr_valid
  );

  modport slave (
    input  TDI, Test_Logic_Reset_in, Capture_IR_in, Shift_IR_in, Update_IR_in,
           Capture_DR_in, Shift_DR_in, Update_DR_in, user_dr_in,
    output TDO, tdo_en, ir_out, user_dr_out, user_dr_valid
  );
endinterface

// File: rtl/jtag_scan_ctrl.sv
// JTAG instruction/data register path: IR plus IDCODE, USER and BYPASS DRs, TDO on falling TCK.
// IR latency 4 shifts, DR latency = selected DR length; no backpressure, the TAP sets the pace.
module jtag_scan_ctrl #(
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5B,
  parameter int          USER_W     = 8
) (
  input  logic            TCK,
  input  logic            TRST_n,
  jtag_scan_ctrl_if.slave bus
);

  localparam logic [3:0] OP_IDCODE = 4'b0001;
  localparam logic [3:0] OP_USER   = 4'b1000;

  typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_USER} dr_sel_e;

  logic [3:0]        ir_shift_q, ir_shift_d;
  logic [3:0]        ir_q, ir_d;
  logic [31:0]       id_sr_q, id_sr_d;
  logic [USER_W-1:0] user_sr_q, user_sr_d;
  logic              byp_sr_q, byp_sr_d;
  logic [USER_W-1:0] user_out_q, user_out_d;
  logic              valid_q, valid_d;
  logic              ir_arm_q, ir_arm_d;
  logic              dr_arm_q, dr_arm_d;
  logic              tdo_q, tdo_d;
  logic              tdo_en_q, tdo_en_d;
  dr_sel_e           sel;

  always_comb begin
    case (ir_q)
      OP_IDCODE: sel = SEL_ID;
      OP_USER:   sel = SEL_USER;
      default:   sel = SEL_BYP;
    endcase
  end

  // Arm flags block an Update from committing data that no Capture has framed (e.g. after a reset).
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    id_sr_d    = id_sr_q;
    user_sr_d  = user_sr_q;
    byp_sr_d   = byp_sr_q;
    user_out_d = user_out_q;
    valid_d    = 1'b0;
    ir_arm_d   = ir_arm_q;
    dr_arm_d   = dr_arm_q;
    if (bus.Test_Logic_Reset_in) begin
      ir_d       = OP_IDCODE;
      ir_shift_d = '0;
      ir_arm_d   = 1'b0;
      dr_arm_d   = 1'b0;
    end else begin
      if (bus.Capture_IR_in) begin
        ir_shift_d = 4'b0001;
        ir_arm_d   = 1'b1;
      end else if (bus.Shift_IR_in) begin
        ir_shift_d = {bus.TDI, ir_shift_q[3:1]};
      end
      if (bus.Update_IR_in && ir_arm_q) begin
        ir_d = ir_shift_q;
      end
      if (bus.Capture_DR_in) begin
        dr_arm_d = 1'b1;
        case (sel)
          SEL_ID:   id_sr_d   = IDCODE_VAL;
          SEL_USER: user_sr_d = bus.user_dr_in;
          default:  byp_sr_d  = 1'b0;
        endcase
      end else if (bus.Shift_DR_in) begin
        case (sel)
          SEL_ID:   id_sr_d   = {bus.TDI, id_sr_q[31:1]};
          SEL_USER: user_sr_d = {bus.TDI, user_sr_q[USER_W-1:1]};
          default:  byp_sr_d  = bus.TDI;
        endcase
      end
      if (bus.Update_DR_in && dr_arm_q && (sel == SEL_USER)) begin
        user_out_d = user_sr_q;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      ir_shift_q <= '0;
      ir_q       <= OP_IDCODE;
      id_sr_q    <= '0;
      user_sr_q  <= '0;
      byp_sr_q   <= 1'b0;
      user_out_q <= '0;
      valid_q    <= 1'b0;
      ir_arm_q   <= 1'b0;
      dr_arm_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      id_sr_q    <= id_sr_d;
      user_sr_q  <= user_sr_d;
      byp_sr_q   <= byp_sr_d;
      user_out_q <= user_out_d;
      valid_q    <= valid_d;
      ir_arm_q   <= ir_arm_d;
      dr_arm_q   <= dr_arm_d;
    end
  end

  // TDO presents the bit that the next rising edge will shift out.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (bus.Shift_IR_in) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (bus.Shift_DR_in) begin
      tdo_en_d = 1'b1;
      case (sel)
        SEL_ID:   tdo_d = id_sr_q[0];
        SEL_USER: tdo_d = user_sr_q[0];
        default:  tdo_d = byp_sr_q;
      endcase
    end
  end

  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign bus.TDO           = tdo_q;
  assign bus.tdo_en        = tdo_en_q;
  assign bus.ir_out        = ir_q;
  assign bus.user_dr_out   = user_out_q;
  assign bus.user_dr_valid = valid_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed bench for jtag_scan_ctrl: vector table for IR/BYPASS flows plus hand sequences for IDCODE, USER, resets.
module tb_jtag_scan_ctrl;

  localparam logic [31:0] IDV = 32'h1234_5A5B;

  // Indicator encoding {TLR, CIR, SIR, UIR, CDR, SDR, UDR}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_TLR  = 7'b1000000;
  localparam logic [6:0] I_CIR  = 7'b0100000;
  localparam logic [6:0] I_SIR  = 7'b0010000;
  localparam logic [6:0] I_UIR  = 7'b0001000;
  localparam logic [6:0] I_CDR  = 7'b0000100;
  localparam logic [6:0] I_SDR  = 7'b0000010;
  localparam logic [6:0] I_UDR  = 7'b0000001;

  typedef struct {
    logic [6:0] ind;
    logic       tdi;
    logic       tdo;
    logic       en;
    logic [3:0] ir;
    logic       vld;
  } vec_t;

  logic TCK = 1'b0;
  logic TRST_n;
  int   tests = 0;
  int   fails = 0;
  logic tdo_s, en_s;
  vec_t tbl[$];

  jtag_scan_ctrl_if #(.USER_W(8)) bus ();

  jtag_scan_ctrl #(.IDCODE_VAL(IDV), .USER_W(8)) dut (
    .TCK    (TCK),
    .TRST_n (TRST_n),
    .bus    (bus)
  );

  always #5 TCK = ~TCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ind(input logic [6:0] v, input logic tdi);
    bus.Test_Logic_Reset_in = v[6];
    bus.Capture_IR_in       = v[5];
    bus.Shift_IR_in         = v[4];
    bus.Update_IR_in        = v[3];
    bus.Capture_DR_in       = v[2];
    bus.Shift_DR_in         = v[1];
    bus.Update_DR_in        = v[0];
    bus.TDI                 = tdi;
  endtask

  // One TCK cycle: drive after a rising edge, sample TDO after the falling edge, return just after the next rising edge.
  task automatic cyc(input logic [6:0] v, input logic tdi);
    set_ind(v, tdi);
    @(negedge TCK);
    #1;
    tdo_s = bus.TDO;
    en_s  = bus.tdo_en;
    @(posedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] op);
    cyc(I_CIR, 1'b0);
    for (int i = 0; i < 4; i++) cyc(I_SIR, op[i]);
    cyc(I_UIR, 1'b0);
  endtask

  task automatic add(input logic [6:0] ind, input logic tdi, input logic tdo, input logic en,
                     input logic [3:0] ir, input logic vld);
    vec_t v;
    v.ind = ind; v.tdi = tdi; v.tdo = tdo; v.en = en; v.ir = ir; v.vld = vld;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] word;
    logic [7:0]  ub;
    logic [7:0]  din;
    logic        all_en;

    // IR 1111 load with TDO 1,0,0,0 then 1-bit bypass; then unknown 0110 acting as bypass.
    add(I_CIR,  1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    add(I_SIR,  1'b1, 1'b1, 1'b1, 4'b1000, 1'b0);
    add(I_SIR,  1'b1, 1'b0, 1'b1, 4'b1000, 1'b0);
    add(I_SIR,  1'b1, 1'b0, 1'b1, 4'b1000, 1'b0);
    add(I_SIR,  1'b1, 1'b0, 1'b1, 4'b1000, 1'b0);
    add(I_UIR,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    add(I_CDR,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    add(I_SDR,  1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    add(I_SDR,  1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
    add(I_SDR,  1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    add(I_NONE, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    add(I_CIR,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    add(I_SIR,  1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
    add(I_SIR,  1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    add(I_SIR,  1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    add(I_SIR,  1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    add(I_UIR,  1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
    add(I_CDR,  1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
    add(I_SDR,  1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    add(I_SDR,  1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    add(I_UDR,  1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
    add(I_NONE, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);

    TRST_n = 1'b0;
    bus.user_dr_in = 8'h00;
    set_ind(I_NONE, 1'b0);
    #12;
    chk("rst_ir_out", 32'(bus.ir_out), 32'h1);
    chk("rst_tdo", 32'(bus.TDO), 32'h0);
    chk("rst_tdo_en", 32'(bus.tdo_en), 32'h0);
    chk("rst_user_dr_out", 32'(bus.user_dr_out), 32'h0);
    chk("rst_user_dr_valid", 32'(bus.user_dr_valid), 32'h0);
    @(posedge TCK);
    #1;
    TRST_n = 1'b1;

    // IDCODE is the default instruction: 32 shifts return the ID LSB-first.
    cyc(I_CDR, 1'b0);
    word = '0;
    all_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc(I_SDR, 1'b0);
      word[i] = tdo_s;
      all_en &= en_s;
    end
    chk("idcode_tdo", word, IDV);
    chk("idcode_tdo_en", 32'(all_en), 32'h1);
    cyc(I_NONE, 1'b0);
    chk("idle_tdo_en", 32'(en_s), 32'h0);

    // USER: capture C3, shift in 5A, update.
    load_ir(4'b1000);
    chk("user_ir_out", 32'(bus.ir_out), 32'h8);
    bus.user_dr_in = 8'hC3;
    cyc(I_CDR, 1'b0);
    din = 8'h5A;
    ub = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(I_SDR, din[i]);
      ub[i] = tdo_s;
    end
    chk("user_tdo", 32'(ub), 32'hC3);
    chk("user_valid_pre", 32'(bus.user_dr_valid), 32'h0);
    cyc(I_UDR, 1'b0);
    chk("user_dr_out", 32'(bus.user_dr_out), 32'h5A);
    chk("user_valid_pulse", 32'(bus.user_dr_valid), 32'h1);
    cyc(I_NONE, 1'b0);
    chk("user_valid_end", 32'(bus.user_dr_valid), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].ind, tbl[i].tdi);
      chk($sformatf("vec%0d_tdo", i), 32'(tdo_s), 32'(tbl[i].tdo));
      chk($sformatf("vec%0d_tdo_en", i), 32'(en_s), 32'(tbl[i].en));
      chk($sformatf("vec%0d_ir_out", i), 32'(bus.ir_out), 32'(tbl[i].ir));
      chk($sformatf("vec%0d_valid", i), 32'(bus.user_dr_valid), 32'(tbl[i].vld));
    end
    chk("unk_op_user_hold", 32'(bus.user_dr_out), 32'h5A);

    // Asynchronous reset in the middle of a USER shift.
    load_ir(4'b1000);
    bus.user_dr_in = 8'hA5;
    cyc(I_CDR, 1'b0);
    for (int i = 0; i < 3; i++) cyc(I_SDR, 1'b1);
    TRST_n = 1'b0;
    #1;
    chk("arst_tdo", 32'(bus.TDO), 32'h0);
    chk("arst_tdo_en", 32'(bus.tdo_en), 32'h0);
    chk("arst_ir_out", 32'(bus.ir_out), 32'h1);
    chk("arst_user_dr_out", 32'(bus.user_dr_out), 32'h0);
    #1;
    TRST_n = 1'b1;
    cyc(I_UDR, 1'b0);
    chk("arst_no_valid", 32'(bus.user_dr_valid), 32'h0);
    cyc(I_UIR, 1'b0);
    chk("arst_uir_no_capture", 32'(bus.ir_out), 32'h1);
    load_ir(4'b1000);
    cyc(I_UDR, 1'b0);
    chk("arst_udr_no_capture_valid", 32'(bus.user_dr_valid), 32'h0);
    chk("arst_udr_no_capture_out", 32'(bus.user_dr_out), 32'h0);

    // Test-Logic-Reset overlapping Shift-DR.
    cyc(I_TLR | I_SDR, 1'b1);
    chk("tlr_ir_out", 32'(bus.ir_out), 32'h1);
    chk("tlr_sdr_tdo_en", 32'(en_s), 32'h1);
    cyc(I_NONE, 1'b0);
    chk("tlr_idle_tdo_en", 32'(en_s), 32'h0);
    cyc(I_CDR, 1'b0);
    cyc(I_SDR, 1'b0);
    chk("tlr_resume_tdo", 32'(tdo_s), 32'(IDV[0]));
    cyc(I_NONE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
